// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side UART framer (start, LSB-first data, optional parity, stop) behind a valid/ready word input
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   tx_data   - word to send, sampled when accepted
//   tx_valid  - source has a word; tx_ready - controller is idle and will take it
//   tx        - registered serial line, idles high
//   busy      - frame in flight; tx_done - one-cycle pulse at end of frame
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               state_q;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q, tx_q, busy_q, done_q, tick;
    always_comb begin
        tick   = baud_q == CW'(CLKS_PER_BIT - 1);
        baud_d = (state_q == IDLE || tick) ? '0 : baud_q + CW'(1);
    end
    // tx_q is loaded with the level of the state being entered, so the line
    // follows the state with no extra cycle of lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            baud_q <= baud_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (tx_valid) begin
                    shift_q <= tx_data;
                    par_q   <= (^tx_data) ^ (PARITY_ODD != 0);
                    state_q <= START;
                    busy_q  <= 1'b1;
                    tx_q    <= 1'b0;
                end
                START: if (tick) begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                end
                DATA: if (tick) begin
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_q   <= '0;
                        state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                        tx_q    <= (PARITY_EN != 0) ? par_q : 1'b1;
                    end else begin
                        bit_q   <= bit_q + 4'd1;
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                    end
                end
                PARITY: if (tick) begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: if (tick) begin
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        bit_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        bit_q <= bit_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign tx_ready = state_q == IDLE;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized and directed frame checks of uart_tx_ctrl against a bit-list frame model
module tb_uart_tx_ctrl;
    localparam int CPB = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [4];
    logic       vin [4];
    logic       txo [4];
    logic       rdy [4];
    logic       bsy [4];
    logic       dn  [4];
    int         pe  [4] = '{0, 1, 1, 0};
    int         po  [4] = '{0, 0, 1, 0};
    int         sb  [4] = '{1, 1, 1, 2};
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) d0 (.clk(clk), .rst(rst), .tx_data(din[0]), .tx_valid(vin[0]),
        .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) d1 (.clk(clk), .rst(rst), .tx_data(din[1]), .tx_valid(vin[1]),
        .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) d2 (.clk(clk), .rst(rst), .tx_data(din[2]),
        .tx_valid(vin[2]), .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) d3 (.clk(clk), .rst(rst), .tx_data(din[3]), .tx_valid(vin[3]),
        .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .tx_done(dn[3]));
    task automatic chk(input string tag, input int d, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, d, $time, o, e);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            step;
            for (int d = 0; d < 4; d++) begin
                chk("idle_tx", d, txo[d], 1'b1);
                chk("idle_done", d, dn[d], 1'b0);
                chk("idle_busy", d, bsy[d], 1'b0);
                chk("idle_ready", d, rdy[d], 1'b1);
            end
        end
    endtask
    // Line model: the frame as a list of bit levels, each held CPB cycles,
    // starting the cycle after the accepting edge; tx_done follows the last one.
    task automatic send(input int d, input logic [7:0] v, input bit hold, input logic [7:0] nxt);
        bit frame[$];
        int ones = 0;
        frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            frame.push_back(v[i]);
            ones += int'(v[i]);
        end
        if (pe[d] != 0) frame.push_back(po[d] != 0 ? (ones % 2 == 0) : (ones % 2 == 1));
        for (int s = 0; s < sb[d]; s++) frame.push_back(1'b1);
        chk("ready_before", d, rdy[d], 1'b1);
        vin[d] = 1'b1;
        din[d] = v;
        for (int i = 0; i < frame.size() * CPB; i++) begin
            step;
            if (i == 0) begin
                vin[d] = hold;
                din[d] = hold ? nxt : 8'hFF;
                chk("busy_set", d, bsy[d], 1'b1);
                chk("ready_low", d, rdy[d], 1'b0);
            end
            if (!hold && i == 20) vin[d] = 1'b1;
            if (!hold && i == 21) vin[d] = 1'b0;
            chk("tx_bit", d, txo[d], frame[i / CPB]);
            chk("done_early", d, dn[d], 1'b0);
        end
        step;
        chk("done_pulse", d, dn[d], 1'b1);
        chk("ready_end", d, rdy[d], 1'b1);
        chk("busy_end", d, bsy[d], 1'b0);
        chk("tx_gap", d, txo[d], 1'b1);
    endtask
    initial begin
        for (int d = 0; d < 4; d++) begin
            vin[d] = 1'b0;
            din[d] = 8'h00;
        end
        repeat (2) step;
        for (int d = 0; d < 4; d++) begin
            chk("rst_tx", d, txo[d], 1'b1);
            chk("rst_ready", d, rdy[d], 1'b1);
            chk("rst_busy", d, bsy[d], 1'b0);
            chk("rst_done", d, dn[d], 1'b0);
        end
        rst = 1'b0;
        idle(2);
        send(0, 8'hA5, 1'b0, 8'h00);
        idle(3);
        send(1, 8'h07, 1'b0, 8'h00);
        idle(1);
        send(2, 8'h07, 1'b0, 8'h00);
        idle(1);
        send(3, 8'($urandom), 1'b0, 8'h00);
        idle(1);
        send(0, 8'h55, 1'b1, 8'hAA);
        send(0, 8'hAA, 1'b0, 8'h00);
        idle(4);
        send(0, 8'h00, 1'b0, 8'h00);
        idle(4);
        vin[0] = 1'b1;
        din[0] = 8'h3C;
        for (int i = 0; i < 18; i++) begin
            step;
            if (i == 0) vin[0] = 1'b0;
        end
        chk("pre_rst_bit3", 0, txo[0], 1'b1);
        rst = 1'b1;
        step;
        chk("midrst_tx", 0, txo[0], 1'b1);
        chk("midrst_busy", 0, bsy[0], 1'b0);
        chk("midrst_ready", 0, rdy[0], 1'b1);
        chk("midrst_done", 0, dn[0], 1'b0);
        rst = 1'b0;
        idle(3);
        send(0, 8'($urandom), 1'b0, 8'h00);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 4; d++) begin
                send(d, 8'($urandom), 1'b0, 8'h00);
                idle(1);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
